// File: rtl/vend_pkg.sv
// Shared constants, coin encoding and FSM states for the change dispenser.
package vend_pkg;

    localparam int unsigned AMT_W = 5;
    localparam int unsigned CNT_W = 4;

    // Coin values in 5-cent units
    localparam logic [AMT_W-1:0] QUARTER = AMT_W'(5);
    localparam logic [AMT_W-1:0] DIME    = AMT_W'(2);
    localparam logic [AMT_W-1:0] NICKEL  = AMT_W'(1);

    typedef struct packed {
        logic quarter;
        logic dime;
        logic nickel;
    } coin_t;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        DONE,
        SHORT
    } state_t;

endpackage

// File: rtl/coin_selector.sv
// Greedy coin choice: largest coin that fits the unpaid amount and is in stock.
module coin_selector
    import vend_pkg::*;
(
    input  logic [AMT_W-1:0] remaining,
    input  logic [CNT_W-1:0] quarter_count,
    input  logic [CNT_W-1:0] dime_count,
    input  logic [CNT_W-1:0] nickel_count,
    output coin_t            coin,
    output logic             none
);

    always_comb begin
        coin = '0;
        if (remaining >= QUARTER && quarter_count != '0) begin
            coin.quarter = 1'b1;
        end else if (remaining >= DIME && dime_count != '0) begin
            coin.dime = 1'b1;
        end else if (remaining >= NICKEL && nickel_count != '0) begin
            coin.nickel = 1'b1;
        end
        none = (coin == '0);
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays a requested amount coin by coin from finite
// quarter/dime/nickel inventories using greedy selection and a hopper handshake.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned QUARTER_INIT = 8,
    parameter int unsigned DIME_INIT    = 8,
    parameter int unsigned NICKEL_INIT  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             changeValid,
    input  logic [AMT_W-1:0] changeAmount,
    output logic             changeReady,
    input  logic             coinAck,
    output logic             ejectQuarter,
    output logic             ejectDime,
    output logic             ejectNickel,
    output logic             changeDone,
    output logic             changeShort,
    output logic [AMT_W-1:0] remaining,
    input  logic             refill,
    output logic [CNT_W-1:0] quarterCount,
    output logic [CNT_W-1:0] dimeCount,
    output logic [CNT_W-1:0] nickelCount
);

    localparam logic [CNT_W-1:0] Q_INIT = CNT_W'(QUARTER_INIT);
    localparam logic [CNT_W-1:0] D_INIT = CNT_W'(DIME_INIT);
    localparam logic [CNT_W-1:0] N_INIT = CNT_W'(NICKEL_INIT);

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] qc_q, qc_d, dc_q, dc_d, nc_q, nc_d;
    coin_t            eject_q, eject_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             short_q, short_d;

    coin_t            sel_coin;
    logic             sel_none;

    coin_selector u_sel (
        .remaining    (rem_q),
        .quarter_count(qc_q),
        .dime_count   (dc_q),
        .nickel_count (nc_q),
        .coin         (sel_coin),
        .none         (sel_none)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            rem_q   <= '0;
            qc_q    <= Q_INIT;
            dc_q    <= D_INIT;
            nc_q    <= N_INIT;
            eject_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            rem_q   <= rem_d;
            qc_q    <= qc_d;
            dc_q    <= dc_d;
            nc_q    <= nc_d;
            eject_q <= eject_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            short_q <= short_d;
        end
    end

    // An accepted request spends one IDLE cycle with ready low before SELECT.
    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        rem_d   = rem_q;
        qc_d    = qc_q;
        dc_d    = dc_q;
        nc_d    = nc_q;
        eject_d = eject_q;

        case (state_q)
            IDLE: begin
                if (refill) begin
                    qc_d = Q_INIT;
                    dc_d = D_INIT;
                    nc_d = N_INIT;
                end
                if (pend_q) begin
                    state_d = SELECT;
                end else if (changeValid && ready_q) begin
                    pend_d = 1'b1;
                    rem_d  = changeAmount;
                end
            end
            SELECT: begin
                if (!sel_none) begin
                    eject_d = sel_coin;
                    state_d = EJECT;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = SHORT;
                end
            end
            EJECT: begin
                if (coinAck) begin
                    eject_d = '0;
                    state_d = SELECT;
                    if (eject_q.quarter) begin
                        rem_d = rem_q - QUARTER;
                        qc_d  = qc_q - CNT_W'(1);
                    end else if (eject_q.dime) begin
                        rem_d = rem_q - DIME;
                        dc_d  = dc_q - CNT_W'(1);
                    end else begin
                        rem_d = rem_q - NICKEL;
                        nc_d  = nc_q - CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            SHORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) && !pend_d;
        done_d  = (state_d == DONE);
        short_d = (state_d == SHORT);
    end

    assign changeReady  = ready_q;
    assign ejectQuarter = eject_q.quarter;
    assign ejectDime    = eject_q.dime;
    assign ejectNickel  = eject_q.nickel;
    assign changeDone   = done_q;
    assign changeShort  = short_q;
    assign remaining    = rem_q;
    assign quarterCount = qc_q;
    assign dimeCount    = dc_q;
    assign nickelCount  = nc_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: three inventory configurations driven against a
// greedy-payout reference model with randomized amounts and hopper delays.
module tb_change_dispenser;

    logic       clock = 1'b0;
    logic       rst_n;
    logic [2:0] valid, ack, refill;
    logic [4:0] amount [3];
    logic [2:0] ready, ejq, ejd, ejn, done, shrt;
    logic [4:0] rem [3];
    logic [3:0] qc [3];
    logic [3:0] dc [3];
    logic [3:0] nc [3];

    int checks = 0;
    int passes = 0;

    // Model state: inventories and unpaid amount per instance
    int init_q [3] = '{8, 1, 8};
    int init_d [3] = '{8, 8, 8};
    int init_n [3] = '{8, 8, 0};
    int mq [3];
    int md [3];
    int mn [3];
    int mrem [3];

    always #5 clock = ~clock;

    change_dispenser u_dut0 (
        .clock(clock), .reset(rst_n), .changeValid(valid[0]), .changeAmount(amount[0]),
        .changeReady(ready[0]), .coinAck(ack[0]), .ejectQuarter(ejq[0]), .ejectDime(ejd[0]),
        .ejectNickel(ejn[0]), .changeDone(done[0]), .changeShort(shrt[0]), .remaining(rem[0]),
        .refill(refill[0]), .quarterCount(qc[0]), .dimeCount(dc[0]), .nickelCount(nc[0])
    );

    change_dispenser #(.QUARTER_INIT(1)) u_dut1 (
        .clock(clock), .reset(rst_n), .changeValid(valid[1]), .changeAmount(amount[1]),
        .changeReady(ready[1]), .coinAck(ack[1]), .ejectQuarter(ejq[1]), .ejectDime(ejd[1]),
        .ejectNickel(ejn[1]), .changeDone(done[1]), .changeShort(shrt[1]), .remaining(rem[1]),
        .refill(refill[1]), .quarterCount(qc[1]), .dimeCount(dc[1]), .nickelCount(nc[1])
    );

    change_dispenser #(.NICKEL_INIT(0)) u_dut2 (
        .clock(clock), .reset(rst_n), .changeValid(valid[2]), .changeAmount(amount[2]),
        .changeReady(ready[2]), .coinAck(ack[2]), .ejectQuarter(ejq[2]), .ejectDime(ejd[2]),
        .ejectNickel(ejn[2]), .changeDone(done[2]), .changeShort(shrt[2]), .remaining(rem[2]),
        .refill(refill[2]), .quarterCount(qc[2]), .dimeCount(dc[2]), .nickelCount(nc[2])
    );

    function automatic logic [2:0] ej(input int k);
        return {ejq[k], ejd[k], ejn[k]};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k] = init_q[k];
            md[k] = init_d[k];
            mn[k] = init_n[k];
            mrem[k] = 0;
        end
    endfunction

    task automatic test_reset();
        logic [22:0] got, exp;
        rst_n = 1'b0;
        valid = '0;
        ack = '0;
        refill = '0;
        for (int k = 0; k < 3; k++) amount[k] = '0;
        model_reset();
        repeat (2) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            got = {ready[k], ej(k), done[k], shrt[k], rem[k], qc[k], dc[k], nc[k]};
            exp = {1'b1, 3'b000, 1'b0, 1'b0, 5'd0, 4'(init_q[k]), 4'(init_d[k]), 4'(init_n[k])};
            checks++;
            if (got !== exp) $display("FAIL reset_state dut%0d: got %h expected %h", k, got, exp);
            else passes++;
        end
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    // One full request on instance k; the model derives coin order and outcome.
    task automatic txn(input int k, input int amt, input bit do_refill, input int hold,
                       input bit poke, input bit poke_refill);
        logic [2:0] coins [$];
        int  r;
        bit  is_short;
        logic [1:0] got_end, exp_end;
        if (do_refill) begin
            mq[k] = init_q[k];
            md[k] = init_d[k];
            mn[k] = init_n[k];
        end
        r = amt;
        while (1) begin
            if (r >= 5 && mq[k] > 0) begin coins.push_back(3'b100); r -= 5; mq[k]--; end
            else if (r >= 2 && md[k] > 0) begin coins.push_back(3'b010); r -= 2; md[k]--; end
            else if (r >= 1 && mn[k] > 0) begin coins.push_back(3'b001); r -= 1; mn[k]--; end
            else break;
        end
        is_short = (r != 0);
        mrem[k] = r;

        @(negedge clock);
        checks++;
        if (ready[k] !== 1'b1) $display("FAIL ready_idle dut%0d: got %b expected 1", k, ready[k]);
        else passes++;
        valid[k] = 1'b1;
        amount[k] = 5'(amt);
        refill[k] = do_refill;
        @(negedge clock);
        valid[k] = 1'b0;
        refill[k] = 1'b0;
        checks++;
        if ({ready[k], ej(k)} !== 4'b0000)
            $display("FAIL accept dut%0d: got %b expected 0000", k, {ready[k], ej(k)});
        else passes++;
        @(negedge clock);
        checks++;
        if ({ej(k), done[k]} !== 4'b0000)
            $display("FAIL select_gap dut%0d: got %b expected 0000", k, {ej(k), done[k]});
        else passes++;

        foreach (coins[i]) begin
            @(negedge clock);
            checks++;
            if (ej(k) !== coins[i])
                $display("FAIL eject dut%0d coin%0d: got %b expected %b", k, i, ej(k), coins[i]);
            else passes++;
            for (int h = 0; h < hold; h++) begin
                if (h == 0 && poke) begin
                    valid[k] = 1'b1;
                    amount[k] = 5'd3;
                    refill[k] = poke_refill;
                end
                @(negedge clock);
                valid[k] = 1'b0;
                refill[k] = 1'b0;
                checks++;
                if ({ready[k], ej(k)} !== {1'b0, coins[i]})
                    $display("FAIL eject_hold dut%0d cycle%0d: got %b expected %b",
                             k, h, {ready[k], ej(k)}, {1'b0, coins[i]});
                else passes++;
            end
            ack[k] = 1'b1;
            @(negedge clock);
            ack[k] = 1'b0;
            checks++;
            if (ej(k) !== 3'b000) $display("FAIL eject_drop dut%0d: got %b expected 000", k, ej(k));
            else passes++;
        end

        @(negedge clock);
        got_end = {done[k], shrt[k]};
        exp_end = {!is_short, is_short};
        checks++;
        if (got_end !== exp_end)
            $display("FAIL outcome dut%0d amt%0d: got %b expected %b", k, amt, got_end, exp_end);
        else passes++;
        checks++;
        if ({rem[k], qc[k], dc[k], nc[k]} !== {5'(mrem[k]), 4'(mq[k]), 4'(md[k]), 4'(mn[k])})
            $display("FAIL totals dut%0d: got rem %0d q%0d d%0d n%0d expected rem %0d q%0d d%0d n%0d",
                     k, rem[k], qc[k], dc[k], nc[k], mrem[k], mq[k], md[k], mn[k]);
        else passes++;
        @(negedge clock);
        checks++;
        if ({done[k], shrt[k], ready[k], rem[k]} !== {3'b001, 5'(mrem[k])})
            $display("FAIL back_idle dut%0d: got %b expected %b",
                     k, {done[k], shrt[k], ready[k], rem[k]}, {3'b001, 5'(mrem[k])});
        else passes++;
    endtask

    task automatic test_basic();
        txn(0, 8, 1'b0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_zero();
        txn(0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_quarter_init();
        txn(1, 5, 1'b0, 1, 1'b0, 1'b0);
        txn(1, 5, 1'b0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_short();
        txn(2, 1, 1'b0, 1, 1'b0, 1'b0);
        txn(2, 5, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ack_hold();
        txn(0, 5, 1'b0, 10, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if ({ready[0], ej(0), done[0]} !== 5'b10000)
                $display("FAIL ignored_request cycle%0d: got %b expected 10000", i, {ready[0], ej(0), done[0]});
            else passes++;
        end
    endtask

    task automatic test_stray_ack();
        @(negedge clock);
        ack[0] = 1'b1;
        repeat (2) @(negedge clock);
        ack[0] = 1'b0;
        @(negedge clock);
        checks++;
        if ({ej(0), qc[0], dc[0], nc[0]} !== {3'b000, 4'(mq[0]), 4'(md[0]), 4'(mn[0])})
            $display("FAIL stray_ack: got q%0d d%0d n%0d expected q%0d d%0d n%0d",
                     qc[0], dc[0], nc[0], mq[0], md[0], mn[0]);
        else passes++;
    endtask

    task automatic test_refill();
        txn(0, 31, 1'b0, 0, 1'b0, 1'b0);
        txn(0, 27, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 31)),
                ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        valid[0] = 1'b1;
        amount[0] = 5'd2;
        refill[0] = 1'b1;
        @(negedge clock);
        valid[0] = 1'b0;
        refill[0] = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (ej(0) !== 3'b010) $display("FAIL mid_dime: got %b expected 010", ej(0));
        else passes++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ready[0], ej(0), rem[0], qc[0], dc[0], nc[0]} !== {1'b1, 3'b000, 5'd0, 4'd8, 4'd8, 4'd8})
            $display("FAIL mid_reset: got %b expected %b", {ready[0], ej(0), rem[0], qc[0], dc[0], nc[0]},
                     {1'b1, 3'b000, 5'd0, 4'd8, 4'd8, 4'd8});
        else passes++;
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        txn(0, 7, 1'b0, 1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_quarter_init();
        test_short();
        test_ack_hold();
        test_stray_ack();
        test_refill();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter QUARTER_INIT, default 8: quarter inventory loaded at reset/refill (0..15).
REQ-002 Parameter DIME_INIT, default 8: dime inventory loaded at reset/refill (0..15).
REQ-003 Parameter NICKEL_INIT, default 8: nickel inventory loaded at reset/refill (0..15).
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 changeValid  input  1  change request strobe from vending machine.
REQ-007 changeAmount  input  5  requested change in 5-cent units (0..31 = 0..155 cents).
REQ-008 changeReady  output  1  high only in IDLE; request accepted when changeValid & changeReady.
REQ-009 coinAck  input  1  hopper confirms the currently requested coin was ejected.
REQ-010 ejectQuarter, ejectDime, ejectNickel  output  1 each  coin eject request, level, held until coinAck.
REQ-011 changeDone  output  1  one-cycle pulse: exact change fully paid.
REQ-012 changeShort  output  1  one-cycle pulse: inventory cannot complete request.
REQ-013 remaining  output  5  unpaid change in 5-cent units.
REQ-014 refill  input  1  reload all inventories to INIT values.
REQ-015 quarterCount, dimeCount, nickelCount  output  4 each  current inventories.

Function
REQ-016 States SHALL be IDLE, SELECT, EJECT, DONE, SHORT; all outputs registered.
REQ-017 IDLE: on changeValid, remaining <= changeAmount, next state SELECT; changeValid ignored in every other state.
REQ-018 SELECT (one cycle), greedy priority: remaining>=5 & quarterCount>0 -> quarter; else remaining>=2 & dimeCount>0 -> dime; else remaining>=1 & nickelCount>0 -> nickel; coin chosen -> EJECT; remaining==0 -> DONE; otherwise -> SHORT.
REQ-019 Exactly one eject line SHALL be high, from the edge entering EJECT until the edge sampling coinAck=1.
REQ-020 On that coinAck edge: eject line low, remaining minus coin value (5/2/1), chosen inventory minus 1, next state SELECT.
REQ-021 Latency: request accepted at edge N -> eject line high from edge N+2; amount 0 -> changeDone high for cycle after edge N+2, no eject.
REQ-022 DONE and SHORT each last one cycle, pulse their output, then return to IDLE.
REQ-023 After SHORT, remaining SHALL hold the unpaid amount until the next accepted request.
REQ-024 Greedy selection is final; no backtracking when a non-greedy combination would have succeeded.
REQ-025 coinAck outside EJECT SHALL be ignored; inventories and remaining never underflow.
REQ-026 refill honoured only in IDLE; refill and changeValid in the same cycle: inventories reloaded and request accepted.

Reset
REQ-027 While reset low: state IDLE, changeReady=1, all eject lines 0, changeDone=0, changeShort=0, remaining=0, counts=INIT values.
REQ-028 Reset asserted mid-operation SHALL drop eject lines immediately and discard the request.

Structure
REQ-029 Package vend_pkg SHALL hold coin unit constants (QUARTER=5, DIME=2, NICKEL=1), amount width 5, and the state enum.
REQ-030 Greedy coin choice SHALL live in combinational sub-module coin_selector (inputs remaining + counts; outputs one-hot coin and none flag).

Verification
REQ-031 Default INIT, changeAmount=8, coinAck one cycle after each eject -> quarter, dime, nickel in order; changeDone; counts 7/7/7; remaining 0.
REQ-032 changeAmount=0 -> changeDone two cycles after accept; no eject line ever high.
REQ-033 QUARTER_INIT=1, two requests of 5 -> first quarter; second dime, dime, nickel; changeDone both times.
REQ-034 NICKEL_INIT=0, changeAmount=1 -> changeShort pulse, remaining=1, no eject.
REQ-035 coinAck delayed 10 cycles, changeValid pulsed during wait -> ejectQuarter held 10 cycles; second request ignored; changeReady low throughout.
REQ-036 reset low while ejectDime high -> ejectDime 0 without clock edge; after release changeReady=1, counts=INIT.
